// File: rtl/mlp_seq.sv
// rtl/mlp_seq.sv - time-multiplexed multilayer perceptron on one saturating MAC
module mlp_seq #(
    parameter int INPUTS        = 2,
    parameter int HIDDEN        = 4,
    parameter int HIDDEN_LAYERS = 1,
    parameter int OUTPUTS       = 1,
    localparam int SW   = 16,
    localparam int NW   = HIDDEN * (INPUTS + 1) + (HIDDEN_LAYERS - 1) * HIDDEN * (HIDDEN + 1)
                          + OUTPUTS * (HIDDEN + 1),
    localparam int AW   = $clog2(NW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUTS*SW-1:0]   in_data,
    input  logic [1:0]             act_hidden,
    input  logic [1:0]             act_output,
    input  logic                   w_we,
    input  logic [AW-1:0]          w_addr,
    input  logic [SW-1:0]          w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUTPUTS*SW-1:0]  out_data,
    output logic                   busy
);
    // sfp is signed Q8.8; products are truncated toward minus infinity
    localparam int FRAC = 8;
    localparam int MAXN = (INPUTS > HIDDEN) ? ((INPUTS > OUTPUTS) ? INPUTS : OUTPUTS)
                                            : ((HIDDEN > OUTPUTS) ? HIDDEN : OUTPUTS);
    localparam int IW   = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam int LW   = $clog2(HIDDEN_LAYERS + 1) + 1;

    localparam logic signed [SW-1:0]   SFP_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0]   SFP_MIN = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [SW-1:0]   ONE     = SW'(1 << FRAC);
    localparam logic signed [SW-1:0]   HALF    = SW'(1 << (FRAC - 1));
    localparam logic signed [2*SW-1:0] SAT_HI  = (2*SW)'(SFP_MAX);
    localparam logic signed [2*SW-1:0] SAT_LO  = (2*SW)'(SFP_MIN);

    localparam logic [1:0] ACT_RELU    = 2'd1;
    localparam logic [1:0] ACT_SIGMOID = 2'd2;

    function automatic logic signed [SW-1:0] sfp_sat(input logic signed [2*SW-1:0] v);
        if (v > SAT_HI)      return SFP_MAX;
        else if (v < SAT_LO) return SFP_MIN;
        else                 return v[SW-1:0];
    endfunction

    function automatic logic signed [SW-1:0] sfp_add(input logic signed [SW-1:0] a,
                                                      input logic signed [SW-1:0] b);
        return sfp_sat((2*SW)'(a) + (2*SW)'(b));
    endfunction

    function automatic logic signed [SW-1:0] sfp_mul(input logic signed [SW-1:0] a,
                                                      input logic signed [SW-1:0] b);
        logic signed [2*SW-1:0] p;
        p = (2*SW)'(a) * (2*SW)'(b);
        return sfp_sat(p >>> FRAC);
    endfunction

    // Unknown activation codes fall through to identity
    function automatic logic signed [SW-1:0] sfp_act(input logic signed [SW-1:0] x,
                                                      input logic [1:0] sel);
        logic signed [SW-1:0] t;
        t = (x >>> 2) + HALF;
        case (sel)
            ACT_RELU:    return x[SW-1] ? '0 : x;
            ACT_SIGMOID: return (t < 0) ? '0 : ((t > ONE) ? ONE : t);
            default:     return x;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

    state_t                state, state_n;
    logic [LW-1:0]         layer;
    logic [IW-1:0]         neuron;
    logic [IW:0]           k;
    logic [AW-1:0]         base;
    logic signed [SW-1:0]  acc;
    logic [1:0]            ah, ao;

    logic signed [SW-1:0]  in_vec  [2**IW];
    logic signed [SW-1:0]  in_lat  [2**IW];
    logic signed [SW-1:0]  pp      [2][2**IW];
    logic signed [SW-1:0]  out_reg [2**IW];
    logic signed [SW-1:0]  wmem    [2**AW];

    logic                  last_layer, last_neuron;
    logic [IW:0]           fan_in, n_neur;
    logic [AW-1:0]         rd_addr;
    logic [IW-1:0]         kidx;
    logic signed [SW-1:0]  w_rd, x_src, act_val;

    for (genvar g = 0; g < 2**IW; g++) begin : g_in
        if (g < INPUTS) begin : g_used
            assign in_vec[g] = in_data[g*SW +: SW];
        end else begin : g_pad
            assign in_vec[g] = '0;
        end
    end

    for (genvar g = 0; g < OUTPUTS; g++) begin : g_out
        assign out_data[g*SW +: SW] = out_reg[g];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // Layer geometry and operand fetch; the bias sits after the weights, so MAC cycle 0 reads it first
    assign last_layer  = (layer == LW'(HIDDEN_LAYERS));
    assign fan_in      = (layer == '0) ? (IW+1)'(INPUTS) : (IW+1)'(HIDDEN);
    assign n_neur      = last_layer ? (IW+1)'(OUTPUTS) : (IW+1)'(HIDDEN);
    assign last_neuron = ({1'b0, neuron} == n_neur - 1'b1);
    assign rd_addr     = (k == '0) ? base + AW'(fan_in) : base + AW'(k) - 1'b1;
    assign kidx        = IW'(k - 1'b1);
    assign w_rd        = wmem[rd_addr];
    assign x_src       = (layer == '0) ? in_lat[kidx] : pp[~layer[0]][kidx];
    assign act_val     = sfp_act(acc, last_layer ? ao : ah);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = MAC;
            MAC:  if (k == fan_in) state_n = ACT;
            ACT:  if (last_neuron && last_layer) state_n = OUT;
                  else state_n = MAC;
            OUT:  if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Weight register file; software writes only land while idle and in range
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wmem <= '{default: '0};
        end else if (w_we && (state == IDLE) && (32'(w_addr) < NW)) begin
            wmem[w_addr] <= w_data;
        end
    end

    // Datapath: input latch, MAC sequencing, activation write-back into the ping-pong buffers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer   <= '0;
            neuron  <= '0;
            k       <= '0;
            base    <= '0;
            acc     <= '0;
            ah      <= '0;
            ao      <= '0;
            in_lat  <= '{default: '0};
            pp      <= '{default: '{default: '0}};
            out_reg <= '{default: '0};
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_lat <= in_vec;
                    ah     <= act_hidden;
                    ao     <= act_output;
                    layer  <= '0;
                    neuron <= '0;
                    k      <= '0;
                    base   <= '0;
                end
                MAC: begin
                    if (k == '0) acc <= w_rd;
                    else         acc <= sfp_add(acc, sfp_mul(w_rd, x_src));
                    k <= k + 1'b1;
                end
                ACT: begin
                    if (last_layer) out_reg[neuron] <= act_val;
                    else            pp[layer[0]][neuron] <= act_val;
                    k    <= '0;
                    base <= base + AW'(fan_in) + 1'b1;
                    if (last_neuron) begin
                        neuron <= '0;
                        if (!last_layer) layer <= layer + 1'b1;
                    end else begin
                        neuron <= neuron + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_seq.sv
// tb/tb_mlp_seq.sv - scoreboard bench for mlp_seq at one and three hidden layers
module tb_mlp_seq;
    localparam int HID = 4;

    logic        clk = 0, rst = 0, in_valid = 0, out_ready = 1;
    logic [31:0] in_data = '0;
    logic [1:0]  act_hidden = '0, act_output = '0;
    logic        w_we1 = 0, w_we3 = 0;
    logic [4:0]  w_addr1 = '0;
    logic [5:0]  w_addr3 = '0;
    logic [15:0] w_data1 = '0, w_data3 = '0;
    logic        in_ready1, in_ready3, out_valid1, out_valid3, busy1, busy3;
    logic [15:0] out_data1, out_data3;

    mlp_seq #(.INPUTS(2), .HIDDEN(HID), .HIDDEN_LAYERS(1), .OUTPUTS(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .act_hidden(act_hidden), .act_output(act_output), .w_we(w_we1), .w_addr(w_addr1),
        .w_data(w_data1), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .busy(busy1));

    mlp_seq #(.INPUTS(2), .HIDDEN(HID), .HIDDEN_LAYERS(3), .OUTPUTS(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .act_hidden(act_hidden), .act_output(act_output), .w_we(w_we3), .w_addr(w_addr3),
        .w_data(w_data3), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .busy(busy3));

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int wm [2][64];
    int exp_q [2][$];
    int acc_q [2][$];
    bit held [2];
    int first_cyc [2];
    int hold_val [2];
    int hl_of [2] = '{1, 3};
    int nw_of [2] = '{17, 57};

    logic               ov [2], ir [2], bz [2];
    logic signed [15:0] od [2];
    assign ov[0] = out_valid1;  assign ov[1] = out_valid3;
    assign ir[0] = in_ready1;   assign ir[1] = in_ready3;
    assign bz[0] = busy1;       assign bz[1] = busy3;
    assign od[0] = out_data1;   assign od[1] = out_data3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    function automatic int sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int smul(input int a, input int b);
        longint p = longint'(a) * longint'(b);
        return sat(p >>> 8);
    endfunction

    function automatic int sact(input int v, input int s);
        int t;
        if (s == 1) return (v < 0) ? 0 : v;
        if (s == 2) begin
            t = (v >>> 2) + 128;
            return (t < 0) ? 0 : ((t > 256) ? 256 : t);
        end
        return v;
    endfunction

    function automatic int cycles(input int hl);
        return HID * (2 + 2) + (hl - 1) * HID * (HID + 2) + (HID + 2);
    endfunction

    // Reference inference: walk the layers with plain integer fixed-point arithmetic
    function automatic int model(input int d, input int x0, input int x1, input int ah, input int ao);
        int cur[$], nxt[$];
        int addr = 0, fan, n, a;
        cur = '{x0, x1};
        for (int l = 0; l <= hl_of[d]; l++) begin
            fan = cur.size();
            n = (l == hl_of[d]) ? 1 : HID;
            nxt.delete();
            for (int j = 0; j < n; j++) begin
                a = wm[d][addr + fan];
                for (int kk = 0; kk < fan; kk++) a = sat(longint'(a) + smul(wm[d][addr + kk], cur[kk]));
                addr += fan + 1;
                nxt.push_back(sact(a, (l == hl_of[d]) ? ao : ah));
            end
            cur = nxt;
        end
        return cur[0];
    endfunction

    // Monitor: record accepts, check hold stability, data and latency at each output handshake
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (in_valid && ir[d]) acc_q[d].push_back(cyc + 1);
                if (ov[d]) begin
                    if (!held[d]) begin
                        held[d] = 1;
                        first_cyc[d] = cyc;
                        hold_val[d] = int'(od[d]);
                    end else begin
                        chk($sformatf("stable%0d", d), int'(od[d]), hold_val[d]);
                    end
                    if (out_ready) begin
                        held[d] = 0;
                        chk($sformatf("pending%0d", d), int'(exp_q[d].size() > 0 && acc_q[d].size() > 0), 1);
                        if (exp_q[d].size() > 0 && acc_q[d].size() > 0) begin
                            chk($sformatf("data%0d", d), int'(od[d]), exp_q[d].pop_front());
                            chk($sformatf("latency%0d", d), first_cyc[d] - acc_q[d].pop_front(),
                                cycles(hl_of[d]));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input int addr, input int val, input bit take);
        if (d == 0) begin w_we1 = 1; w_addr1 = 5'(addr); w_data1 = 16'(val); end
        else        begin w_we3 = 1; w_addr3 = 6'(addr); w_data3 = 16'(val); end
        tick();
        w_we1 = 0;
        w_we3 = 0;
        if (take && addr < nw_of[d]) wm[d][addr] = val;
    endtask

    task automatic load(input int d, input int hw, input int hb, input int ow, input int ob);
        int a = 0, fan, n;
        for (int l = 0; l <= hl_of[d]; l++) begin
            fan = (l == 0) ? 2 : HID;
            n = (l == hl_of[d]) ? 1 : HID;
            for (int j = 0; j < n; j++) begin
                for (int kk = 0; kk < fan; kk++) begin wr(d, a, (l == hl_of[d]) ? ow : hw, 1); a++; end
                wr(d, a, (l == hl_of[d]) ? ob : hb, 1);
                a++;
            end
        end
    endtask

    task automatic load_both(input int hw, input int hb, input int ow, input int ob);
        load(0, hw, hb, ow, ob);
        load(1, hw, hb, ow, ob);
    endtask

    task automatic send(input int x0, input int x1, input int ah, input int ao);
        int n = 0;
        while (!(in_ready1 && in_ready3) && n < 400) begin tick(); n++; end
        chk("ready_wait", int'(in_ready1 && in_ready3), 1);
        in_data = {16'(x1), 16'(x0)};
        act_hidden = 2'(ah);
        act_output = 2'(ao);
        in_valid = 1;
        exp_q[0].push_back(model(0, x0, x1, ah, ao));
        exp_q[1].push_back(model(1, x0, x1, ah, ao));
        tick();
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size()) > 0 && n < 400) begin tick(); n++; end
        chk("drain", exp_q[0].size() + exp_q[1].size(), 0);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready1"}, int'(in_ready1), 1);
        chk({tag, "_in_ready3"}, int'(in_ready3), 1);
        chk({tag, "_out_valid1"}, int'(out_valid1), 0);
        chk({tag, "_out_valid3"}, int'(out_valid3), 0);
        chk({tag, "_busy1"}, int'(busy1), 0);
        chk({tag, "_busy3"}, int'(busy3), 0);
        chk({tag, "_out_data1"}, int'(out_data1), 0);
        chk({tag, "_out_data3"}, int'(out_data3), 0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        rst = 1;
        chk_idle("por");

        // Reset mid-MAC aborts the computation and clears the weights
        load_both(128, 0, 64, 26);
        send(256, 512, 0, 0);
        repeat (3) tick();
        chk("busy1_mid", int'(busy1), 1);
        chk("busy3_mid", int'(busy3), 1);
        rst = 0;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            acc_q[d].delete();
            held[d] = 0;
            for (int a = 0; a < 64; a++) wm[d][a] = 0;
        end
        repeat (2) tick();
        rst = 1;
        chk_idle("rst");
        send(256, 512, 0, 0);
        drain();

        // Linear inference, then ReLU clipping of negative hidden sums
        load_both(128, 0, 64, 26);
        send(256, 512, 0, 0);
        drain();
        load_both(128, -768, 64, 26);
        send(256, 512, 1, 0);
        drain();

        // Backpressure: output held, second vector not accepted
        load_both(128, 0, 64, 26);
        out_ready = 0;
        send(256, 512, 0, 0);
        n = 0;
        while (!out_valid3 && n < 200) begin tick(); n++; end
        chk("bp_reach_out", int'(out_valid3), 1);
        in_valid = 1;
        in_data = {16'(100), 16'(200)};
        repeat (10) begin
            tick();
            chk("bp_in_ready1", int'(in_ready1), 0);
            chk("bp_in_ready3", int'(in_ready3), 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready1_after", int'(in_ready1), 1);
        chk("bp_ready3_after", int'(in_ready3), 1);
        tick();
        drain();

        // Saturation at the sfp maximum
        load_both(32767, 32767, 32767, 32767);
        send(32767, 32767, 0, 0);
        drain();

        // Dropped writes: while busy and beyond the weight range
        load_both(128, 0, 64, 26);
        send(256, 512, 0, 0);
        repeat (2) tick();
        wr(0, 0, -32768, 0);
        wr(1, 0, -32768, 0);
        drain();
        wr(0, 20, -32768, 1);
        wr(1, 60, -32768, 1);
        send(256, 512, 0, 0);
        drain();

        // Depth: doubling through the hidden layers
        load_both(128, 0, 64, 0);
        send(256, 256, 0, 0);
        drain();

        // Randomized weights, inputs and activation selections
        repeat (6) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < nw_of[d]; a++) wr(d, a, int'($urandom_range(512)) - 256, 1);
            send(int'($urandom_range(1024)) - 512, int'($urandom_range(1024)) - 512,
                 int'($urandom_range(3)), int'($urandom_range(3)));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
